// File: rtl/down_count_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : down_count_ctrl                                            |
// | Description : Next-state and control stage feeding the 4-bit state       |
// |               register of the down-counter. Loads a start value, counts  |
// |               down one step per enabled tick and reports terminal count  |
// |               with a single-cycle done pulse. Presents a start/busy/done |
// |               handshake to the surrounding control logic.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   WIDTH     - bit width of load_val and count (default 4)                |
// |                                                                          |
// | Ports                                                                    |
// |   clk       in   1      system clock, rising-edge active                  |
// |   reset_n   in   1      asynchronous active-low reset                     |
// |   start     in   1      load load_val and begin counting (IDLE only)      |
// |   load_val  in   WIDTH  start value captured on an accepted start         |
// |   tick      in   1      count enable, one decrement per cycle in COUNT    |
// |   abort     in   1      synchronous cancel back to IDLE                   |
// |   count     out  WIDTH  registered current count (drives register d)     |
// |   busy      out  1      registered, high while counting or in DONE        |
// |   done      out  1      registered single-cycle terminal-count pulse      |
// |   zero      out  1      combinational, count == 0                         |
// |                                                                          |
// | Build option                                                             |
// |   DOWN_COUNT_AUTO_RELOAD_EN - when defined, reaching terminal count in   |
// |   COUNT reloads the captured start value and keeps counting (done still |
// |   pulses). When undefined the counter is one-shot.                       |
// +--------------------------------------------------------------------------+

module down_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic             busy_q;
   logic             done_q;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;
`endif

   // Helper decodes used by the state machine.
   logic             w_accept_start;   // start taken this cycle (abort wins)
   logic             w_load_is_zero;   // zero-length request goes straight to DONE
   logic             w_last_tick;      // this tick moves count from 1 to 0
   logic [WIDTH-1:0] w_count_dec;

   assign w_accept_start = start & ~abort;
   assign w_load_is_zero = (load_val == c_zero);
   assign w_last_tick    = tick & (count_q == c_one);
   assign w_count_dec    = count_q - c_one;

   // ------------------------------------------------------------------------
   // Single-process state machine. busy and done are registered alongside
   // the state so that they are glitch-free and line up with count.
   // done defaults low every cycle, which makes it a one-cycle pulse.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         count_q  <= c_zero;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
         reload_q <= c_zero;
`endif
      end else begin
         done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (w_accept_start) begin
                  count_q <= load_val;
                  busy_q  <= 1'b1;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
                  reload_q <= load_val;
`endif
                  if (w_load_is_zero) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_COUNT;
                  end
               end
            end

            S_COUNT: begin
               // abort has priority over tick; start is not looked at here.
               if (abort) begin
                  state_q <= S_IDLE;
                  count_q <= c_zero;
                  busy_q  <= 1'b0;
               end else if (w_last_tick) begin
                  done_q <= 1'b1;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
                  // Wrap back to the captured start value and keep counting.
                  count_q <= reload_q;
`else
                  count_q <= c_zero;
                  state_q <= S_DONE;
`endif
               end else if (tick) begin
                  // count is at least 2 here, so this can never underflow.
                  count_q <= w_count_dec;
               end
            end

            S_DONE: begin
               // One-cycle state; abort makes no difference. count is
               // already 0 on every path into DONE.
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               count_q <= c_zero;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign zero  = (count_q == c_zero);

endmodule

`default_nettype wire

// File: tb/tb_down_count_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_down_count_ctrl                                         |
// | Description : Self-checking bench for down_count_ctrl. Directed cases    |
// |               for reset, one-shot, gated ticks, abort priority, zero     |
// |               load and ignored start, then a randomized run compared     |
// |               against a behavioural reference model.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_down_count_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         tick = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         zero;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: a counter that is either idle, running, or sitting in
   // its one-cycle completion phase.
   bit m_running;
   bit m_finishing;
   bit m_pulse;
   int m_value;
   int m_start_value;

   down_count_ctrl #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .load_val (load_val),
      .tick     (tick),
      .abort    (abort),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_running     = 0;
      m_finishing   = 0;
      m_pulse       = 0;
      m_value       = 0;
      m_start_value = 0;
   endfunction

   function automatic void model_cycle(input bit st, input int lv, input bit tk, input bit ab);
      m_pulse = 0;
      if (m_finishing) begin
         m_finishing = 0;
         m_running   = 0;
      end else if (!m_running) begin
         if (st && !ab) begin
            m_value       = lv;
            m_start_value = lv;
            m_running     = 1;
            if (lv == 0) begin
               m_finishing = 1;
               m_pulse     = 1;
            end
         end
      end else if (ab) begin
         m_value   = 0;
         m_running = 0;
      end else if (tk) begin
         m_value = m_value - 1;
         if (m_value == 0) begin
            m_pulse = 1;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
            m_value = m_start_value;
`else
            m_finishing = 1;
`endif
         end
      end
   endfunction

   task automatic compare_model(input string tag);
      check_value({tag, ".count"}, count, m_value);
      check_value({tag, ".busy"},  busy,  m_running);
      check_value({tag, ".done"},  done,  m_pulse);
      check_value({tag, ".zero"},  zero,  (m_value == 0));
   endtask

   // Drive one cycle of inputs, advance the model on the same edge and
   // compare 1 time unit after that edge.
   task automatic step(input bit st, input int lv, input bit tk, input bit ab, input string tag);
      @(negedge clk);
      start    = st;
      load_val = W'(lv);
      tick     = tk;
      abort    = ab;
      @(posedge clk);
      model_cycle(st, lv, tk, ab);
      #1;
      compare_model(tag);
   endtask

   task automatic expect_outputs(input string tag, input int c, input bit b, input bit d);
      check_value({tag, ".count"}, count, c);
      check_value({tag, ".busy"},  busy,  b);
      check_value({tag, ".done"},  done,  d);
   endtask

   initial begin
      model_reset();

      // Asynchronous reset before any clock edge has occurred.
      #1 reset_n = 1'b0;
      #1;
      expect_outputs("rst_async", 0, 1'b0, 1'b0);
      check_value("rst_async.zero", zero, 1);
      @(negedge clk);
      reset_n = 1'b1;

`ifndef DOWN_COUNT_AUTO_RELOAD_EN
      // One-shot: load 3 with continuous tick.
      step(1, 3, 1, 0, "os_load");  expect_outputs("os_c3", 3, 1, 0);
      step(0, 0, 1, 0, "os_t1");    expect_outputs("os_c2", 2, 1, 0);
      step(0, 0, 1, 0, "os_t2");    expect_outputs("os_c1", 1, 1, 0);
      step(0, 0, 1, 0, "os_t3");    expect_outputs("os_c0", 0, 1, 1);
      step(0, 0, 1, 0, "os_idle");  expect_outputs("os_end", 0, 0, 0);

      // Gated ticks: load 2, tick 1,0,0,1.
      step(1, 2, 0, 0, "gt_load");  expect_outputs("gt_c2", 2, 1, 0);
      step(0, 0, 1, 0, "gt_t1");    expect_outputs("gt_c1a", 1, 1, 0);
      step(0, 0, 0, 0, "gt_t0a");   expect_outputs("gt_c1b", 1, 1, 0);
      step(0, 0, 0, 0, "gt_t0b");   expect_outputs("gt_c1c", 1, 1, 0);
      step(0, 0, 1, 0, "gt_t2");    expect_outputs("gt_c0", 0, 1, 1);
      step(0, 0, 0, 0, "gt_idle");  expect_outputs("gt_end", 0, 0, 0);
`else
      // Auto-reload: load 2, continuous tick, then abort.
      step(1, 2, 1, 0, "ar_load");  expect_outputs("ar_c2a", 2, 1, 0);
      step(0, 0, 1, 0, "ar_t1");    expect_outputs("ar_c1a", 1, 1, 0);
      step(0, 0, 1, 0, "ar_t2");    expect_outputs("ar_c2b", 2, 1, 1);
      step(0, 0, 1, 0, "ar_t3");    expect_outputs("ar_c1b", 1, 1, 0);
      step(0, 0, 1, 0, "ar_t4");    expect_outputs("ar_c2c", 2, 1, 1);
      step(0, 0, 1, 1, "ar_abort"); expect_outputs("ar_end", 0, 0, 0);
`endif

      // abort beats tick in COUNT.
      step(1, 5, 0, 0, "ab_load");  expect_outputs("ab_c5", 5, 1, 0);
      step(0, 0, 1, 1, "ab_hit");   expect_outputs("ab_idle", 0, 0, 0);
      step(0, 0, 0, 0, "ab_after"); expect_outputs("ab_nodone", 0, 0, 0);

      // start together with abort in IDLE loads nothing.
      step(1, 7, 0, 1, "sa_both");  expect_outputs("sa_idle", 0, 0, 0);

      // Zero-length count.
      step(1, 0, 0, 0, "z_load");   expect_outputs("z_done", 0, 1, 1);
      step(0, 0, 0, 0, "z_idle");   expect_outputs("z_end", 0, 0, 0);

      // start while busy is ignored.
      step(1, 12, 0, 0, "ig_load"); expect_outputs("ig_c12", 12, 1, 0);
      step(0, 0, 1, 0, "ig_t1");    expect_outputs("ig_c11", 11, 1, 0);
      step(1, 9, 0, 0, "ig_start"); expect_outputs("ig_hold", 11, 1, 0);
      step(1, 9, 1, 0, "ig_st_tk"); expect_outputs("ig_c10", 10, 1, 0);

      // Full-range load, then asynchronous reset mid-cycle while counting.
      step(0, 0, 0, 1, "fr_clear");
      step(1, 15, 1, 0, "fr_load"); expect_outputs("fr_c15", 15, 1, 0);
      step(0, 0, 1, 0, "fr_t1");    expect_outputs("fr_c14", 14, 1, 0);
      #3 reset_n = 1'b0;
      #1;
      expect_outputs("rst_mid", 0, 0, 0);
      check_value("rst_mid.zero", zero, 1);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 1, 0, "rst_post"); expect_outputs("rst_nodone", 0, 0, 0);

      // Randomized run against the model.
      for (int i = 0; i < 600; i++) begin
         bit st;
         bit tk;
         bit ab;
         int lv;
         st = ($urandom_range(0, 3) == 0);
         tk = ($urandom_range(0, 3) != 0);
         ab = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 5))
            0:       lv = 0;
            1:       lv = 15;
            2:       lv = 1;
            default: lv = $urandom_range(0, 15);
         endcase
         step(st, lv, tk, ab, "rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/down_count_ctrl.md
Name: down_count_ctrl

Overview:
- Next-state and control stage directly upstream of the 4-bit state register in the down-counter design.
- Loads a start value, decrements on each enabled tick, and signals terminal count through a done pulse.
- Its registered count output drives the register's d input.
- Presents a start/busy/done handshake to the surrounding control logic.

Parameters:
- WIDTH, 4, bit width of the load value and count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to load load_val and begin counting; sampled only in IDLE.
- load_val  input  WIDTH  start value captured on an accepted start.
- tick  input  1  count enable; one decrement per clk cycle in which tick=1 while in COUNT.
- abort  input  1  synchronous cancel; returns to IDLE.
- count  output  WIDTH  registered current count; feeds the downstream register's d input.
- busy  output  1  registered; high in COUNT and DONE.
- done  output  1  registered; single-cycle pulse at terminal count.
- zero  output  1  combinational, (count == 0).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset (reset_n=0, asynchronous, regardless of clk):
  - state=IDLE, count=0, reload register=0.
  - busy=0, done=0, zero=1.
  - Reset asserted mid-count aborts immediately. No done pulse is produced.
- States are IDLE, COUNT and DONE; encoding is free.
- IDLE:
  - start=1 and abort=0: count<=load_val and reload<=load_val on that edge.
  - If load_val!=0, next state is COUNT.
  - If load_val==0, next state is DONE (zero-length count).
  - Otherwise count holds its value.
- COUNT:
  - abort=1: count<=0, go IDLE. abort beats tick.
  - tick=1 and count>1: count<=count-1.
  - tick=1 and count==1: count<=0, go DONE.
  - tick=0: hold.
  - start is ignored in COUNT.
- DONE:
  - Lasts exactly one cycle; done=1 during that cycle.
  - count stays 0. Next state is IDLE unconditionally.
  - abort in DONE also goes to IDLE (no difference).
  - start is ignored in DONE.
- Outputs are registered and derived from state:
  - busy=1 in COUNT and DONE.
  - done=1 only in DONE.
- Latency:
  - count reflects load_val one cycle after the accepted start edge.
  - done rises on the edge after the tick that reaches 0.
  - A load of N with continuous tick gives done high in the (N+1)th cycle after start.
- Arithmetic: unsigned modulo-2^WIDTH. Underflow cannot occur because the 1->0 decrement exits COUNT.
- Simultaneous start+abort in IDLE: abort wins; stays IDLE, count unchanged.
- load_val=2^WIDTH-1 is legal and counts the full range.

Optional Feature:
- Macro: DOWN_COUNT_AUTO_RELOAD_EN.
- Defined:
  - In COUNT, a tick with count==1 loads count<=reload, stays in COUNT, and asserts done for that one cycle.
  - busy stays 1 until abort. DONE is reached only for a zero load_val.
  - A zero load_val still goes DONE then IDLE.
- Undefined: behaviour as above (one-shot). The reload register may be optimised away.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle -> count=0, busy=0, done=0, zero=1 immediately, with no clk edge needed.
- One-shot: start with load_val=3, tick held 1 -> count 3,2,1,0 on successive cycles; done=1 for exactly one cycle when count first reads 0; busy falls the cycle after.
- Gated ticks: load_val=2, tick pattern 1,0,0,1 -> count 2,1,1,1,0; done pulses once after the second tick.
- Abort/priority:
  - In COUNT with count=5, abort=1 and tick=1 together -> count=0, state IDLE, no done pulse.
  - start=1 and abort=1 in IDLE -> nothing loaded.
- Zero and ignored start:
  - load_val=0 start -> busy=1, done=1 for one cycle, then IDLE.
  - start while busy with load_val=9 -> ignored; count continues unchanged.
- With DOWN_COUNT_AUTO_RELOAD_EN: load_val=2, continuous tick -> count 2,1,2,1,2; done high each cycle count reloads to 2; busy stays 1 until abort.
